// File: rtl/ysyx_22041752_store_buffer.sv
// Posted-write store buffer between the EXU load/store port and the AXI arbiter.
// Stores are queued in a small FIFO and drained in program order whenever the
// downstream port is free; loads that do not touch a queued 8-byte word (and
// are not in device space while stores are pending) bypass the queue.
// At most one downstream transaction is outstanding at any time.
module ysyx_22041752_store_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] MMIO_TOP = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_en,
  input  logic [7:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [63:0] data_wdata,
  output logic        data_ready,
  output logic [63:0] data_rdata,
  output logic        data_valid,
  output logic        mem_en,
  output logic [7:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RREQ,
    S_RRESP,
    S_WREQ,
    S_WRESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Queue storage; an entry is live when its offset from head is below count.
  logic [31:0] r_addr  [DEPTH];
  logic [7:0]  r_wen   [DEPTH];
  logic [63:0] r_wdata [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_ld_addr;

  logic             w_is_store;
  logic             w_full;
  logic             w_conflict;
  logic             w_push;
  logic             w_pop;
  logic             w_ld_accept;
  logic [DEPTH-1:0] w_hit;

  assign w_is_store = |data_wen;
  assign w_full     = (r_count == CW'(DEPTH));

  // Per-entry word match; the head entry remains live until its write response.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      logic [PW-1:0] w_off;
      assign w_off     = PW'(gi) - r_head;
      assign w_hit[gi] = ({1'b0, w_off} < r_count) &&
                         (r_addr[gi][31:3] == data_addr[31:3]);
    end
  endgenerate

  // Device-space loads must see every earlier store land first.
  assign w_conflict  = (|w_hit) || ((data_addr < MMIO_TOP) && (r_count != '0));
  assign w_push      = data_en && w_is_store && !w_full;
  assign w_ld_accept = data_en && !w_is_store && (r_state == S_IDLE) && !w_conflict;
  assign w_pop       = (r_state == S_WRESP) && mem_valid;

  // Accept handshake toward the EXU.
  always_comb begin
    data_ready = 1'b0;
    if (data_en) begin
      data_ready = w_is_store ? !w_full : ((r_state == S_IDLE) && !w_conflict);
    end
  end

  // Store payload write at the tail slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail]  <= data_addr;
      r_wen[r_tail]   <= data_wen;
      r_wdata[r_tail] <= data_wdata;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Latch the accepted load address for the read request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_addr <= '0;
    end else if (w_ld_accept) begin
      r_ld_addr <= data_addr;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and downstream / response outputs; loads win over draining.
  always_comb begin
    w_state_next = r_state;
    mem_en       = 1'b0;
    mem_wen      = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    data_rdata   = '0;
    data_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ld_accept) begin
          w_state_next = S_RREQ;
        end else if (r_count != '0) begin
          w_state_next = S_WREQ;
        end
      end
      S_RREQ: begin
        mem_en   = 1'b1;
        mem_addr = r_ld_addr;
        if (mem_ready) w_state_next = S_RRESP;
      end
      S_RRESP: begin
        data_rdata = mem_rdata;
        data_valid = mem_valid;
        if (mem_valid) w_state_next = S_IDLE;
      end
      S_WREQ: begin
        mem_en    = 1'b1;
        mem_addr  = r_addr[r_head];
        mem_wen   = r_wen[r_head];
        mem_wdata = r_wdata[r_head];
        if (mem_ready) w_state_next = S_WRESP;
      end
      S_WRESP: begin
        if (mem_valid) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041752_store_buffer.sv
// Bench for the store buffer: a randomised arbiter model, an EXU driver, and
// a program-order memory reference that predicts every load result.
module tb_ysyx_22041752_store_buffer;

  logic        clk;
  logic        reset;
  logic        data_en;
  logic [7:0]  data_wen;
  logic [31:0] data_addr;
  logic [63:0] data_wdata;
  logic        data_ready;
  logic [63:0] data_rdata;
  logic        data_valid;
  logic        mem_en;
  logic [7:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        mem_valid;

  ysyx_22041752_store_buffer #(.DEPTH(4), .MMIO_TOP(32'h8000_0000)) dut (
    .clk(clk), .reset(reset),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_rdata(data_rdata), .data_valid(data_valid),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  wen;
    logic [63:0] wdata;
  } st_t;

  typedef struct {
    bit          has_store;
    logic [31:0] st_addr;
    logic [31:0] ld_addr;
    logic        exp_ready;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int n_dv = 0;
  int n_ld = 0;

  st_t         st_q[$];       // stores accepted but not yet seen downstream
  logic [31:0] rd_q[$];       // loads accepted but not yet seen downstream
  logic        log_wr[$];     // downstream transaction order
  logic [31:0] log_addr[$];
  logic [63:0] phys_mem [logic [28:0]];  // what the arbiter's memory holds
  logic [63:0] ref_mem  [logic [28:0]];  // memory as seen in program order
  bit          mem_block;
  bit          arb_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] mem_init(input logic [28:0] w);
    return {w, 3'b101, ~w, 3'b010};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] wen,
                                        input logic [63:0] wd);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (wen[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Arbiter model: random accept and completion delays, one transaction at a time.
  st_t         cap_e;
  logic [7:0]  cap_wen;
  logic [31:0] cap_addr;
  logic [63:0] cap_wdata;
  logic [63:0] cap_rd;
  logic [28:0] cap_w;
  logic [31:0] cap_exp;
  initial begin
    mem_ready = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    arb_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1 && !mem_block && reset === 1'b0) begin
        arb_busy = 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cap_wen = mem_wen; cap_addr = mem_addr; cap_wdata = mem_wdata;
        cap_w   = mem_addr[31:3];
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        log_wr.push_back(cap_wen != 8'h00);
        log_addr.push_back(cap_addr);
        cap_rd = '0;
        if (cap_wen != 8'h00) begin
          chk("write_expected", 64'(st_q.size() != 0), 64'd1);
          if (st_q.size() != 0) begin
            cap_e = st_q.pop_front();
            chk("wr_addr_wen", {cap_wen, cap_addr}, {cap_e.wen, cap_e.addr});
            chk("wr_data", cap_wdata, cap_e.wdata);
          end
          phys_mem[cap_w] = merge(phys_mem.exists(cap_w) ? phys_mem[cap_w] : mem_init(cap_w),
                                  cap_wen, cap_wdata);
        end else begin
          chk("read_expected", 64'(rd_q.size() != 0), 64'd1);
          if (rd_q.size() != 0) begin
            cap_exp = rd_q.pop_front();
            chk("rd_addr", {8'h00, cap_addr}, {8'h00, cap_exp});
          end
          cap_rd = phys_mem.exists(cap_w) ? phys_mem[cap_w] : mem_init(cap_w);
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        mem_rdata = cap_rd;
        mem_valid = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        mem_rdata = '0;
        arb_busy  = 1'b0;
      end
    end
  end

  // Count every load-response pulse.
  initial forever begin
    @(negedge clk);
    if (data_valid === 1'b1) n_dv++;
  end

  // Issue one EXU request and, for loads, wait for and check the response.
  task automatic do_req(input logic [7:0] wen, input logic [31:0] addr, input logic [63:0] wdata);
    int          n;
    bit          ok;
    logic [28:0] w;
    logic [63:0] exp;
    data_en = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wdata;
    w = addr[31:3];
    exp = '0;
    n = 0; ok = 1'b1;
    @(negedge clk);
    while (data_ready !== 1'b1) begin
      n++;
      if (n >= 400) begin ok = 1'b0; break; end
      @(negedge clk);
    end
    chk("accept", 64'(ok), 64'd1);
    if (ok) begin
      if (wen != 8'h00) begin
        st_q.push_back('{addr: addr, wen: wen, wdata: wdata});
        ref_mem[w] = merge(ref_mem.exists(w) ? ref_mem[w] : mem_init(w), wen, wdata);
      end else begin
        exp = ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
        rd_q.push_back(addr);
        n_ld++;
      end
    end
    @(posedge clk); #1;
    data_en = 1'b0; data_wen = '0;
    if (ok && wen == 8'h00) begin
      n = 0; ok = 1'b0;
      while (n < 400) begin
        @(negedge clk);
        if (data_valid === 1'b1) begin ok = 1'b1; break; end
        n++;
      end
      chk("load_resp_seen", 64'(ok), 64'd1);
      if (ok) chk("load_data", data_rdata, exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    data_en = 1'b0; data_wen = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    st_q.delete(); rd_q.delete();
    log_wr.delete(); log_addr.delete();
    ref_mem = phys_mem;
  endtask

  task automatic wait_drain();
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    while (n < 500) begin
      @(negedge clk);
      if (st_q.size() == 0 && !arb_busy && mem_en === 1'b0) begin ok = 1'b1; break; end
      n++;
    end
    chk("drain_done", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_log(input string name, input int idx, input logic wr, input logic [31:0] a);
    chk({name, "_present"}, 64'(log_wr.size() > idx), 64'd1);
    if (log_wr.size() > idx) chk(name, {31'd0, log_wr[idx], a}, {31'd0, wr, log_addr[idx]});
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] a;
    logic [7:0]  wn;
    logic [63:0] wd;
    int          n;
    bit          ok;

    vecs[0] = '{1'b1, 32'h8000_0100, 32'h8000_0104, 1'b0};
    vecs[1] = '{1'b1, 32'h8000_0100, 32'h8000_0200, 1'b1};
    vecs[2] = '{1'b1, 32'h8000_0100, 32'h0200_BFF8, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_0100, 32'h8000_0108, 1'b1};
    vecs[4] = '{1'b1, 32'h8000_0100, 32'h7FFF_FFF8, 1'b0};
    vecs[5] = '{1'b1, 32'h8000_0100, 32'h8000_0000, 1'b1};
    vecs[6] = '{1'b1, 32'h8000_01F8, 32'h8000_01FC, 1'b0};
    vecs[7] = '{1'b0, 32'h0,         32'h0200_BFF8, 1'b1};
    vecs[8] = '{1'b0, 32'h0,         32'h8000_0100, 1'b1};

    reset = 1'b1; data_en = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    mem_block = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_data_valid", 64'(data_valid), 64'd0);
    chk("rst_mem_en",     64'(mem_en), 64'd0);
    chk("rst_mem_wen",    64'(mem_wen), 64'd0);
    chk("rst_mem_addr",   64'(mem_addr), 64'd0);
    chk("rst_mem_wdata",  mem_wdata, 64'd0);
    chk("rst_data_rdata", data_rdata, 64'd0);
    @(posedge clk); #1;

    // Load acceptance versus the queue contents, one queued store at most.
    mem_block = 1'b1;
    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].has_store) do_req(8'hFF, vecs[i].st_addr, 64'h1234);
      data_en = 1'b1; data_wen = '0; data_addr = vecs[i].ld_addr;
      @(negedge clk);
      chk($sformatf("vec%0d_load_ready", i), 64'(data_ready), 64'(vecs[i].exp_ready));
      @(posedge clk); #1;
      data_en = 1'b0;
      do_reset();
    end
    mem_block = 1'b0;

    // Fill to DEPTH, refusal while full, push offered in the pop cycle.
    mem_block = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) do_req(8'hFF, 32'h8000_0000 + 32'(i * 8), 64'(i + 1));
    data_en = 1'b1; data_wen = 8'hFF; data_addr = 32'h8000_0020; data_wdata = 64'd5;
    @(negedge clk);
    chk("full_refuse", 64'(data_ready), 64'd0);
    chk("wreq_hold_en", 64'(mem_en), 64'd1);
    chk("wreq_hold_addr", 64'(mem_addr), 64'h8000_0000);
    @(posedge clk); #1;
    mem_block = 1'b0;
    n = 0; ok = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin ok = 1'b1; break; end
      n++;
    end
    chk("pop_seen", 64'(ok), 64'd1);
    chk("pop_cycle_refuse", 64'(data_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_pop_accept", 64'(data_ready), 64'd1);
    if (data_ready === 1'b1) st_q.push_back('{addr: 32'h8000_0020, wen: 8'hFF, wdata: 64'd5});
    @(posedge clk); #1;
    data_addr = 32'h8000_0028; data_wdata = 64'd6;
    @(negedge clk);
    chk("still_full", 64'(data_ready), 64'd0);
    @(posedge clk); #1;
    data_en = 1'b0; data_wen = '0;
    wait_drain();
    chk("drain_count", 64'(log_wr.size()), 64'd5);

    // Same-word load waits behind the store.
    do_reset();
    do_req(8'hFF, 32'h8000_0100, 64'h11);
    do_req(8'h00, 32'h8000_0104, 64'h0);
    check_log("raw_first_write", 0, 1'b1, 32'h8000_0100);
    check_log("raw_then_read", 1, 1'b0, 32'h8000_0104);
    wait_drain();

    // Non-conflicting load bypasses a queued store.
    do_reset();
    phys_mem[29'h1000_0040] = 64'hDEAD;
    ref_mem[29'h1000_0040]  = 64'hDEAD;
    do_req(8'hFF, 32'h8000_0100, 64'h22);
    do_req(8'h00, 32'h8000_0200, 64'h0);
    check_log("bypass_read_first", 0, 1'b0, 32'h8000_0200);
    wait_drain();
    check_log("bypass_write_after", 1, 1'b1, 32'h8000_0100);

    // Device-space load waits for a full drain.
    do_reset();
    do_req(8'hFF, 32'h8000_0100, 64'h33);
    do_req(8'h00, 32'h0200_BFF8, 64'h0);
    check_log("mmio_write_first", 0, 1'b1, 32'h8000_0100);
    check_log("mmio_read_after", 1, 1'b0, 32'h0200_BFF8);
    wait_drain();

    // Reset while a read request is pending with two stores queued.
    mem_block = 1'b1;
    do_reset();
    data_en = 1'b1; data_wen = '0; data_addr = 32'h8000_0300;
    @(negedge clk);
    chk("rr_load_ready", 64'(data_ready), 64'd1);
    @(posedge clk); #1;
    data_en = 1'b0;
    do_req(8'hFF, 32'h8000_0300, 64'h44);
    do_req(8'hFF, 32'h8000_0308, 64'h55);
    @(negedge clk);
    chk("rreq_fields", {mem_en, mem_wen, mem_addr}, {1'b1, 8'h00, 32'h8000_0300});
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    st_q.delete(); rd_q.delete(); log_wr.delete(); log_addr.delete();
    ref_mem = phys_mem;
    @(negedge clk);
    chk("rst_mid_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mid_dvalid", 64'(data_valid), 64'd0);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_en !== 1'b0) ok = 1'b0;
    end
    chk("rst_mid_no_drain", 64'(ok), 64'd1);
    @(posedge clk); #1;
    data_en = 1'b1; data_wen = '0; data_addr = 32'h8000_0300;
    @(negedge clk);
    chk("rst_mid_queue_empty", 64'(data_ready), 64'd1);
    @(posedge clk); #1;
    do_reset();
    mem_block = 1'b0;

    // Randomised traffic against the program-order memory reference.
    for (int i = 0; i < 150; i++) begin
      a = (($urandom_range(0, 7) == 0) ? 32'h0200_0000 : 32'h8000_0000) +
          32'($urandom_range(0, 7) * 8);
      a[2:0] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        wn = 8'($urandom_range(1, 255));
        wd = {$urandom, $urandom};
      end else begin
        wn = 8'h00;
        wd = '0;
      end
      do_req(wn, a, wd);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain();
    chk("dvalid_pulses", 64'(n_dv), 64'(n_ld));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
